// File: rtl/uart_pkg.sv
// uart_pkg -- shared types and legal-range constants for the UART transmitter.
//   uart_state_t  : transmitter FSM state encoding
//   DATA_BITS_MIN / DATA_BITS_MAX / STOP_BITS_MAX : parameter limits
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state).
package uart_pkg;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 8;
  localparam int STOP_BITS_MAX = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen -- bit-period timer for the UART transmitter.
//   clk  : clock
//   rst  : synchronous active-high reset
//   en   : count enable; counter is held at zero while low
//   tick : high in the last cycle of each CLK_DIV-cycle bit period
module uart_baud_gen #(
  parameter int CLK_DIV = 104
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV + 1);

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("uart_baud_gen: CLK_DIV must be >= 1");
  end

  logic [CW-1:0] cnt;
  logic          last;

  assign last = (cnt == CW'(CLK_DIV - 1));
  assign tick = en && last;

  // Clearing while disabled means a frame always starts on a full bit period.
  always_ff @(posedge clk) begin
    if (rst || !en)  cnt <= '0;
    else if (last)   cnt <= '0;
    else             cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param -- parameterized UART transmitter (start, LSB-first data,
// optional parity, 1..2 stop bits), valid/ready byte input.
//   clk      : clock
//   rst      : synchronous active-high reset
//   tx_data  : byte to send (bits above DATA_BITS-1 ignored)
//   tx_valid : send request, taken when tx_ready is high
//   tx_ready : block idle and able to accept a byte
//   tx_done  : one-cycle pulse after the last stop cycle
//   tx       : serial line, idle high
// Optional feature macro: UART_TX_PARITY_EN -- inserts a parity bit after the
// data bits (even, or odd when PARITY_ODD=1). Undefined: no parity logic.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 104,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx
);

  localparam int BW = $clog2(DATA_BITS + 1);

  if (CLK_DIV < 1 || DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
      STOP_BITS < 1 || STOP_BITS > STOP_BITS_MAX ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_tx_param: illegal parameter value");
  end

  uart_state_t          state;
  logic [DATA_BITS-1:0] shreg;
  logic [BW-1:0]        bit_cnt;
  logic                 tick;
`ifdef UART_TX_PARITY_EN
  logic                 par;
`endif

  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .en   (state != IDLE),
    .tick (tick)
  );

  assign tx_ready = (state == IDLE);

  always_comb begin
    tx = 1'b1;
    case (state)
      START:  tx = 1'b0;
      DATA:   tx = shreg[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx = par;
`endif
      default: tx = 1'b1;
    endcase
  end

  // bit_cnt counts data bits in DATA and is reused to count stop bits in STOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid) begin
            state   <= START;
            shreg   <= tx_data[DATA_BITS-1:0];
            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            // Parity is fixed at accept time so later tx_data changes are moot.
            par     <= (^tx_data[DATA_BITS-1:0]) ^ (PARITY_ODD != 0);
`endif
          end
        end
        START: if (tick) state <= DATA;
        DATA: begin
          if (tick) begin
            shreg <= shreg >> 1;
            if (bit_cnt == BW'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (tick) state <= STOP;
`endif
        STOP: begin
          if (tick) begin
            if (bit_cnt == BW'(STOP_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= IDLE;
              tx_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param -- scoreboard bench for uart_tx_param.
// Two instances run concurrently:
//   dut0: CLK_DIV=4, DATA_BITS=8, STOP_BITS=1, PARITY_ODD=0
//   dut1: CLK_DIV=1, DATA_BITS=5, STOP_BITS=2, PARITY_ODD=1
// On every accepted byte the expected per-cycle {tx, tx_done, tx_ready}
// waveform is pushed; the negedge monitor pops one entry per cycle (idle
// values when empty). Honors UART_TX_PARITY_EN.
module tb_uart_tx_param;

  localparam int CDV [2] = '{4, 1};
  localparam int DBV [2] = '{8, 5};
  localparam int SBV [2] = '{1, 2};
  localparam int POV [2] = '{0, 1};
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LA = (1 + 8 + P + 1) * 4;
  localparam int LB = (1 + 5 + P + 2) * 1;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst;
  logic [1:0] tx_valid;
  logic [1:0] tx_ready;
  logic [1:0] tx_done;
  logic [1:0] tx;
  logic [7:0] tx_data [2];

  logic [2:0] q [2][$];
  logic [1:0] exp_rdy = 2'b11;
  int         checks = 0;
  int         fails  = 0;
  bit         mon_en = 1'b0;

  for (genvar g = 0; g < 2; g++) begin : gd
    uart_tx_param #(
      .CLK_DIV(CDV[g]), .DATA_BITS(DBV[g]), .STOP_BITS(SBV[g]), .PARITY_ODD(POV[g])
    ) dut (
      .clk(clk), .rst(rst[g]), .tx_data(tx_data[g]), .tx_valid(tx_valid[g]),
      .tx_ready(tx_ready[g]), .tx_done(tx_done[g]), .tx(tx[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Expected waveform entry = {tx, tx_done, tx_ready}.
  task automatic push_frame(input int g, input logic [7:0] d);
    logic par;
    par = 1'b0;
    for (int c = 0; c < CDV[g]; c++) q[g].push_back(3'b000);
    for (int b = 0; b < DBV[g]; b++) begin
      par ^= d[b];
      for (int c = 0; c < CDV[g]; c++) q[g].push_back({d[b], 2'b00});
    end
`ifdef UART_TX_PARITY_EN
    par ^= (POV[g] != 0);
    for (int c = 0; c < CDV[g]; c++) q[g].push_back({par, 2'b00});
`endif
    for (int c = 0; c < SBV[g] * CDV[g]; c++) q[g].push_back(3'b100);
    q[g].push_back(3'b111);
  endtask

  // Acceptance model: bench-side ready, reset wins over valid.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst[g])                          q[g].delete();
      else if (tx_valid[g] && exp_rdy[g])  push_frame(g, tx_data[g]);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      for (int g = 0; g < 2; g++) begin
        logic [2:0] e;
        e = (q[g].size() != 0) ? q[g].pop_front() : 3'b101;
        exp_rdy[g] = e[0];
        chk($sformatf("dut%0d tx/done/ready", g), {29'd0, tx[g], tx_done[g], tx_ready[g]}, {29'd0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int g, input logic [7:0] d);
    tx_data[g]  = d;
    tx_valid[g] = 1'b1;
    tick();
    tx_valid[g] = 1'b0;
  endtask

  localparam logic [7:0] VA [4] = '{8'hA5, 8'h00, 8'hFF, 8'h81};
  localparam logic [7:0] VB [3] = '{8'hFF, 8'hE3, 8'h14};

  initial begin
    rst = 2'b11; tx_valid = 2'b00; tx_data[0] = 8'h00; tx_data[1] = 8'h00;
    tick();
    mon_en = 1'b1;
    tick();
    rst = 2'b00;
    tick();
    fork
      begin : seq_a
        foreach (VA[i]) begin
          send(0, VA[i]);
          repeat (LA + 3) tick();
        end
        // back-to-back with valid held high throughout
        tx_data[0] = 8'h55; tx_valid[0] = 1'b1;
        tick();
        tx_data[0] = 8'h0F;
        repeat (LA + 1) tick();
        tx_valid[0] = 1'b0;
        repeat (LA + 3) tick();
        // reset at cycle 12 of a frame, then a clean frame
        send(0, 8'h3C);
        repeat (11) tick();
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        repeat (4) tick();
        // reset while idle with valid high: nothing may be accepted
        rst[0] = 1'b1; tx_data[0] = 8'h77; tx_valid[0] = 1'b1;
        tick();
        rst[0] = 1'b0; tx_valid[0] = 1'b0;
        repeat (4) tick();
        send(0, 8'hC3);
        repeat (LA + 3) tick();
        // valid/data churn during a frame
        send(0, 8'h96);
        for (int i = 0; i < 20; i++) begin
          tx_valid[0] = i[0];
          tx_data[0]  = 8'(i * 37);
          tick();
        end
        tx_valid[0] = 1'b0;
        repeat (LA) tick();
      end
      begin : seq_b
        foreach (VB[i]) begin
          send(1, VB[i]);
          repeat (LB + 3) tick();
        end
        tx_data[1] = 8'h0A; tx_valid[1] = 1'b1;
        tick();
        tx_data[1] = 8'h15;
        repeat (LB + 1) tick();
        tx_valid[1] = 1'b0;
        repeat (LB + 3) tick();
      end
    join
    repeat (5) tick();
    chk("dut0 expected frames drained", q[0].size(), 0);
    chk("dut1 expected frames drained", q[1].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter CLK_DIV, default 104, meaning clk cycles per bit period; legal range >= 1.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..8.
REQ-003 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal range 1..2.
REQ-004 SHALL have parameter PARITY_ODD, default 0, meaning 0 = even parity, 1 = odd parity; it takes effect only with UART_TX_PARITY_EN.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-007 SHALL have port tx_data, input, 8, the byte to send; bits above DATA_BITS-1 are ignored.
REQ-008 SHALL have port tx_valid, input, 1, request to send tx_data.
REQ-009 SHALL have port tx_ready, output, 1, high when the block can accept a byte.
REQ-010 SHALL have port tx_done, output, 1, a one-cycle pulse when a frame completes.
REQ-011 SHALL have port tx, output, 1, the serial line; idle level is high.

Function
REQ-012 SHALL accept a byte at a posedge where tx_valid && tx_ready; it latches tx_data and drops tx_ready in the next cycle.
REQ-013 SHALL ignore tx_valid while tx_ready is low; tx_data changes during a frame SHALL NOT affect the frame.
REQ-014 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; transitions are IDLE->START on accept, START->DATA, DATA->PARITY (macro defined) or DATA->STOP, PARITY->STOP, STOP->IDLE.
REQ-015 SHALL drive each bit for exactly CLK_DIV cycles: start bit low, then DATA_BITS data bits LSB first, then the optional parity bit, then STOP_BITS*CLK_DIV cycles high.
REQ-016 SHALL drive the start bit beginning the cycle after acceptance; frame length = (1+DATA_BITS+P+STOP_BITS)*CLK_DIV cycles, where P = 1 with the macro and 0 without.
REQ-017 SHALL assert tx_done for one cycle, with tx_ready high, in the cycle after the final stop cycle.
REQ-018 SHALL allow back-to-back frames: an accept in the tx_done cycle starts the next start bit in the following cycle, with no extra idle cycle.
REQ-019 SHALL use a bit counter of width $clog2(DATA_BITS+1) and a baud counter of width $clog2(CLK_DIV+1); the baud counter wraps CLK_DIV-1 -> 0 with a tick at CLK_DIV-1.
REQ-020 SHALL work at CLK_DIV = 1, with every bit lasting one cycle.
REQ-021 SHALL fail elaboration for illegal parameter values.

Reset
REQ-022 SHALL, while rst is high at a posedge, set state=IDLE, tx=1, tx_ready=1, tx_done=0, and clear the counters and shift register.
REQ-023 SHALL on reset mid-frame abort the frame, drive tx high from the next cycle, and emit no tx_done.
REQ-024 SHALL give rst priority over a simultaneous tx_valid; no byte is accepted in that cycle.

Configuration
REQ-025 SHALL, when UART_TX_PARITY_EN is defined, insert one parity bit after the data bits: XOR of the DATA_BITS sent, inverted when PARITY_ODD=1.
REQ-026 SHALL, when UART_TX_PARITY_EN is undefined, omit the PARITY state and parity logic entirely and ignore PARITY_ODD.

Structure
REQ-027 SHALL place the state enum typedef and legal-range constants (DATA_BITS_MIN=5, DATA_BITS_MAX=8, STOP_BITS_MAX=2) in shared package uart_pkg.
REQ-028 SHALL implement the baud counter as sub-module uart_baud_gen (parameter CLK_DIV; ports clk, rst, en, tick); the counter is cleared whenever en is low.

Verification
REQ-029 SHALL cover: CLK_DIV=4, DATA_BITS=8, no parity, accept 0xA5 at cycle 0 -> tx = 0,1,0,1,0,0,1,0,1 then stop 1, each bit 4 cycles over cycles 1-40; tx_done pulses at cycle 41.
REQ-030 SHALL cover: macro defined, 0xA5 -> parity bit 0 with PARITY_ODD=0 and 1 with PARITY_ODD=1; frame length is 44 cycles at CLK_DIV=4.
REQ-031 SHALL cover: DATA_BITS=5, STOP_BITS=2, CLK_DIV=1, send 0xFF -> tx = 0,1,1,1,1,1,1,1 over 8 cycles, then tx_done.
REQ-032 SHALL cover: tx_valid held high for two bytes 0x55 and 0x0F -> the second start bit immediately follows the first frame's stop period, with two tx_done pulses.
REQ-033 SHALL cover: rst asserted at cycle 12 of a frame -> tx=1 and tx_ready=1 from cycle 13, and no tx_done; the next accept sends a full, correct frame.
REQ-034 SHALL cover: tx_valid toggled and tx_data changed mid-frame -> the frame content is unchanged and no extra frame is sent.
